// File: rtl/bitwise_logic_unit_if.sv
// Handshake bundle for bitwise_logic_unit: operand/opcode
// input channel and buffered result output channel.
interface bitwise_logic_unit_if #(
  parameter int K     = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic          acc_sel;
  logic [K-1:0]  inputA;
  logic [K-1:0]  inputB;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  outputC;
  logic          out_zero;
  logic [CW-1:0] count;

  modport master (
    output in_valid, op, acc_sel,
    output inputA, inputB, out_ready,
    input  in_ready, out_valid,
    input  outputC, out_zero, count
  );

  modport slave (
    input  in_valid, op, acc_sel,
    input  inputA, inputB, out_ready,
    output in_ready, out_valid,
    output outputC, out_zero, count
  );
endinterface

// File: rtl/bitwise_logic_unit.sv
// Registered 8-op bitwise unit with output FIFO.
// Define BWLU_ACCUM_EN for the accumulator operand-A path.
module bitwise_logic_unit #(
  parameter int K     = 16,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  bitwise_logic_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [K-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] zf_q;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [K-1:0]     opa;
  logic [K-1:0]     res;
  logic             push, pop;

`ifdef BWLU_ACCUM_EN
  logic [K-1:0] acc_q, acc_d;

  always_comb begin
    opa = bus.acc_sel ? acc_q : bus.inputA;
  end

  always_comb begin
    acc_d = acc_q;
    if (push) acc_d = res;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`else
  logic unused_acc_sel;
  assign unused_acc_sel = bus.acc_sel;

  always_comb begin
    opa = bus.inputA;
  end
`endif

  always_comb begin
    res = '0;
    unique case (bus.op)
      3'b000: res = opa & bus.inputB;
      3'b001: res = opa | bus.inputB;
      3'b010: res = opa ^ bus.inputB;
      3'b011: res = ~(opa ^ bus.inputB);
      3'b100: res = ~(opa & bus.inputB);
      3'b101: res = ~(opa | bus.inputB);
      3'b110: res = ~opa;
      3'b111: res = opa;
      default: res = '0;
    endcase
  end

  // Full FIFO may still accept when the head leaves this cycle
  assign bus.in_ready  = (count_q < CW'(DEPTH)) || bus.out_ready;
  assign bus.out_valid = (count_q != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not cleared; the empty head is masked below
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q] <= res;
      zf_q[wptr_q]  <= (res == '0);
    end
  end

  assign bus.outputC  = bus.out_valid ? mem_q[rptr_q] : '0;
  assign bus.out_zero = bus.out_valid ? zf_q[rptr_q] : 1'b1;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit (K=16, DEPTH=4):
// vector tables, directed corner sequences and random traffic.
module tb_bitwise_logic_unit;
  localparam int K = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 0;

  logic [K-1:0] q[$];
  logic [K-1:0] acc = '0;

  bitwise_logic_unit_if #(.K(K), .DEPTH(D)) bus ();

  bitwise_logic_unit #(.K(K), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [K-1:0] a;
    logic [K-1:0] b;
    logic [K-1:0] exp;
    logic         expz;
  } vec_t;

  typedef struct {
    logic         sel;
    logic [2:0]   op;
    logic [K-1:0] a;
    logic [K-1:0] b;
    logic [K-1:0] exp;
  } acc_vec_t;

  task automatic check(string n, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               n, act, exp, $time);
    end
  endtask

  function automatic logic [K-1:0] ref_op(
    logic [2:0] op, logic [K-1:0] a, logic [K-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  // Inputs are set at a falling edge; check, then clock
  task automatic tick();
    bit push, pop;
    logic [K-1:0] ea, r;
    int n;
    #1;
    n = q.size();
    if (chk_en) begin
      check("count", 32'(bus.count), n);
      check("out_valid", 32'(bus.out_valid), 32'(n != 0));
      check("in_ready", 32'(bus.in_ready),
            32'((n < D) || bus.out_ready));
      if (n != 0) begin
        check("outputC", 32'(bus.outputC), 32'(q[0]));
        check("out_zero", 32'(bus.out_zero),
              32'(q[0] == '0));
      end
    end
    push = bus.in_valid && ((n < D) || bus.out_ready);
    pop  = (n != 0) && bus.out_ready;
    ea = bus.inputA;
`ifdef BWLU_ACCUM_EN
    if (bus.acc_sel) ea = acc;
`endif
    r = ref_op(bus.op, ea, bus.inputB);
    @(posedge clk);
    if (rst) begin
      q.delete();
      acc = '0;
      chk_en = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(r);
        acc = r;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(bit v, bit rdy, logic [2:0] op,
                       logic [K-1:0] a, logic [K-1:0] b,
                       bit sel);
    bus.in_valid  = v;
    bus.out_ready = rdy;
    bus.op        = op;
    bus.inputA    = a;
    bus.inputB    = b;
    bus.acc_sel   = sel;
  endtask

  task automatic drain();
    drive(0, 1, 3'd0, '0, '0, 0);
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    check("drain_empty", 32'(bus.count), 0);
  endtask

  vec_t     tbl [9];
  acc_vec_t atbl [3];

  initial begin
    tbl[0] = '{3'd0, 16'h000F, 16'h000A, 16'h000A, 1'b0};
    tbl[1] = '{3'd1, 16'h000F, 16'h000A, 16'h000F, 1'b0};
    tbl[2] = '{3'd2, 16'h000F, 16'h000A, 16'h0005, 1'b0};
    tbl[3] = '{3'd3, 16'h000F, 16'h000A, 16'hFFFA, 1'b0};
    tbl[4] = '{3'd4, 16'h000F, 16'h000A, 16'hFFF5, 1'b0};
    tbl[5] = '{3'd5, 16'h000F, 16'h000A, 16'hFFF0, 1'b0};
    tbl[6] = '{3'd6, 16'h000F, 16'h000A, 16'hFFF0, 1'b0};
    tbl[7] = '{3'd7, 16'h000F, 16'h000A, 16'h000F, 1'b0};
    tbl[8] = '{3'd2, 16'h1234, 16'h1234, 16'h0000, 1'b1};
    atbl[0] = '{1'b0, 3'd7, 16'h00FF, 16'h0000, 16'h00FF};
`ifdef BWLU_ACCUM_EN
    atbl[1] = '{1'b1, 3'd2, 16'h1234, 16'h0F0F, 16'h0FF0};
    atbl[2] = '{1'b1, 3'd6, 16'h1234, 16'h0000, 16'hF00F};
`else
    atbl[1] = '{1'b1, 3'd2, 16'h1234, 16'h0F0F, 16'h1D3B};
    atbl[2] = '{1'b1, 3'd6, 16'h1234, 16'h0000, 16'hEDCB};
`endif

    // Reset held two cycles with traffic offered
    rst = 1'b1;
    drive(1, 0, 3'd7, 16'hBEEF, 16'h0, 0);
    tick();
    tick();
    check("rst_count", 32'(bus.count), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_outC", 32'(bus.outputC), 0);
    check("rst_zero", 32'(bus.out_zero), 1);
    check("rst_inrdy", 32'(bus.in_ready), 1);
    rst = 1'b0;
    drive(0, 1, 3'd0, '0, '0, 0);
    tick();
    tick();
    check("post_rst_empty", 32'(bus.out_valid), 0);

    // Opcode sweep, streaming with out_ready high
    foreach (tbl[i]) begin
      drive(1, 1, tbl[i].op, tbl[i].a, tbl[i].b, 0);
      tick();
      check($sformatf("sweep%0d_C", i),
            32'(bus.outputC), 32'(tbl[i].exp));
      check($sformatf("sweep%0d_z", i),
            32'(bus.out_zero), 32'(tbl[i].expz));
      check($sformatf("sweep%0d_v", i),
            32'(bus.out_valid), 1);
    end
    drain();

    // Fill with backpressure, then push/pop through wrap
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 3'd7, 16'(16'h100 + i), '0, 0);
      tick();
    end
    check("full_count", 32'(bus.count), 4);
    #1 check("full_inrdy", 32'(bus.in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 3'd7, 16'(16'h200 + i), '0, 0);
      tick();
      check("pp_count", 32'(bus.count), 4);
    end
    drain();

    // Single push then immediate pop
    drive(1, 0, 3'd6, 16'h00F0, '0, 0);
    tick();
    check("one_count", 32'(bus.count), 1);
    drive(0, 1, 3'd0, '0, '0, 0);
    tick();
    check("one_popped", 32'(bus.count), 0);
    check("one_valid", 32'(bus.out_valid), 0);

    // Reset with three entries queued and push+pop active
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 3'd1, 16'(16'h30 + i), 16'h1, 0);
      tick();
    end
    rst = 1'b1;
    drive(1, 1, 3'd7, 16'h5555, '0, 0);
    tick();
    rst = 1'b0;
    check("mrst_count", 32'(bus.count), 0);
    drive(1, 0, 3'd7, 16'hFFFF, '0, 0);
    tick();
    check("mrst_count1", 32'(bus.count), 1);
    check("mrst_head", 32'(bus.outputC), 32'h0000FFFF);
    drain();

    // Accumulator feedback chain
    foreach (atbl[i]) begin
      drive(1, 1, atbl[i].op, atbl[i].a, atbl[i].b,
            atbl[i].sel);
      tick();
      check($sformatf("acc%0d", i),
            32'(bus.outputC), 32'(atbl[i].exp));
    end
    drain();

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 2) != 0),
            3'($urandom), 16'($urandom), 16'($urandom),
            bit'($urandom));
      tick();
    end
    rst = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, registered bitwise logic unit for the ALU datapath. It generalises the fixed 16-bit XNOR stage to eight selectable bitwise operations. Results are buffered in an output FIFO behind a valid/ready handshake, with an optional accumulator feedback path. It sits between the operand/opcode decoder and the ALU result mux.

## Interface
Parameters:
- `K`, 16, operand/result width in bits (≥1).
- `DEPTH`, 4, output FIFO entries (power of 2, ≥2).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operands/opcode valid.
- `in_ready`  out  1  unit can accept this cycle.
- `op`  in  3  operation select.
- `acc_sel`  in  1  use accumulator as operand A. Ignored when `BWLU_ACCUM_EN` is undefined.
- `inputA`  in  K  operand A.
- `inputB`  in  K  operand B.
- `out_valid`  out  1  FIFO head holds a result.
- `out_ready`  in  1  consumer takes head this cycle.
- `outputC`  out  K  FIFO head result.
- `out_zero`  out  1  FIFO head result is all zeros.
- `count`  out  $clog2(DEPTH)+1  occupied FIFO entries.

## Operation
- Opcodes, with A the effective operand A:
  - 000: A&B
  - 001: A|B
  - 010: A^B
  - 011: ~(A^B)
  - 100: ~(A&B)
  - 101: ~(A|B)
  - 110: ~A (B ignored)
  - 111: A (B ignored)
- Push occurs when `in_valid && in_ready`. The computed result and its zero flag are written to the FIFO tail at that edge.
- Pop occurs when `out_valid && out_ready`. The head is discarded at that edge.
- `in_ready = (count < DEPTH) || out_ready`. This is a combinational path from `out_ready`, and it allows push+pop in the same cycle when full.
- `out_valid = (count != 0)`.
- `outputC` and `out_zero` are driven from the head entry only. They are don't-care when `out_valid=0`, but must not glitch while `out_valid=1` and no pop occurs.
- Count arithmetic per edge:
  - push only: +1
  - pop only: −1
  - both: unchanged
- Read/write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH` with no gap.
- Push while full without a pop is impossible by construction. `in_ready` is low in that case, so no write occurs.
- Pop while empty is impossible: `out_valid` is low, so no pointer movement occurs.
- Results are bit-exact K-bit. There is no carry and no sign interpretation.

## Timing
- Latency: a result pushed at edge N is visible on `outputC` with `out_valid=1` in the cycle after edge N, when the FIFO was empty. Otherwise it is visible after all older entries are popped.
- Throughput: one transaction per cycle, sustained when `out_ready=1`.
- Reset values (after any edge with `rst=1`):
  - `count=0`, `out_valid=0`, `in_ready=1`
  - pointers 0
  - `outputC=0`, `out_zero=1` (entries are not cleared, but the head output is forced to 0 while empty after reset)
  - accumulator = 0
- `rst` dominates push/pop in the same edge. The FIFO is flushed, and in-flight data mid-stream is lost, with no partial state.
- `in_ready` is high during reset cycles, but transactions in those cycles are discarded.

## Configuration
- `BWLU_ACCUM_EN` defined:
  - A K-bit accumulator register exists. It is loaded with the result of every push.
  - When `acc_sel=1` on a push, effective A = accumulator and `inputA` is ignored.
  - The accumulator is reset to 0 by `rst`. It is not affected by pops or FIFO fullness; only pushes update it.
- `BWLU_ACCUM_EN` undefined:
  - No accumulator register exists, and `acc_sel` is ignored.
  - Effective A = `inputA` always.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid=1` → `count=0`, `out_valid=0`, `outputC=0`, `out_zero=1`, and nothing is popped afterwards.
- Opcode sweep, K=16, A=0x000F, B=0x000A, `out_ready=1`, all 8 ops → results 0x000A, 0x000F, 0x0005, 0xFFFA, 0xFFF5, 0xFFF0, 0xFFF0, 0x000F, each one cycle after push. Also A=B=0x1234 with op 010 → 0x0000, `out_zero=1`.
- Fill and backpressure, DEPTH=4, `out_ready=0`: push 5 times → first 4 accepted, `count=4`, `in_ready=0`. Then `out_ready=1` with `in_valid=1` → simultaneous push/pop, `count` stays 4, and order is preserved through pointer wrap (drain 8 entries in order).
- Empty boundary: single push then immediate pop → `count` 1→0, `out_valid` low the following cycle.
- Mid-stream reset: 3 entries queued, assert `rst` with push+pop active → `count=0` next cycle, and the next push (A=0xFFFF, op 111) emerges alone as 0xFFFF.
- Accumulator, with macro defined:
  - push A=0x00FF op 111 → acc=0x00FF
  - push `acc_sel=1` B=0x0F0F op 010 → 0x0FF0
  - push `acc_sel=1` op 110 → 0xF00F
  - With macro undefined, the same stimulus yields 0x00FF, 0x0F0F^`inputA`, ~`inputA`.
